alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, registered successor to the single-cycle combinational ALU. Sits in the EX stage of the 3-stage pipeline.
- Accepts one operation per cycle over a valid/ready handshake and returns a registered result with condition flags and a pass-through tag (destination register index).
- Adds an iterative multi-cycle multiply, enabled by a macro, that stalls the issue side while it runs.

Parameters:
- WIDTH, 32: operand and result width in bits; must be a power of two, 8 to 64.
- TAG_W, 5: width of the pass-through tag.
- SH_W (localparam), $clog2(WIDTH): width of the shift-amount field.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept an operation this cycle.
- in_op  in  4  opcode, encoded in alu_pkg.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_tag  in  TAG_W  tag, returned unchanged with the result.
- out_valid  out  1  result held in the output register.
- out_ready  in  1  consumer takes the result this cycle.
- out_result  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.
- out_zero  out  1  result == 0.
- out_carry  out  1  ADD: carry-out. SUB: no-borrow (a >= b unsigned). Other ops: 0.
- out_ovf  out  1  signed overflow for ADD/SUB; 0 for other ops.
- busy  out  1  multiply in progress.

Behaviour:
- Opcodes:
  - 0 ADD; 1 SUB (a + ~b + 1).
  - 2 SRA, 3 SRL, 4 SLL. Shift amount is b[SH_W-1:0] only; upper bits of b are ignored.
  - 5 AND, 6 OR, 7 XOR.
  - 8 SLT signed, 9 SLTU. Result is zero-extended 1/0.
  - 10 PASSB (result = b).
  - 11 MUL: low WIDTH bits of a*b; see Optional Feature.
  - 12-15: result 0, all flags clear except out_zero = 1.
- Handshake:
  - Transfer on the input side when in_valid && in_ready. Transfer on the output side when out_valid && out_ready.
  - in_ready = rst_n && state==IDLE && (!out_valid || out_ready).
- Single-cycle ops:
  - Latency 1: an op accepted in cycle N has out_valid high in cycle N+1.
  - Throughput is 1 per cycle when out_ready is held high. A simultaneous output transfer and input accept is legal: the output register is overwritten with the new result.
- Stall: while out_valid && !out_ready, out_result, out_tag and all flags hold stable. out_valid never drops without an output transfer.
- FSM states IDLE, MUL, DONE:
  - IDLE -> MUL on accepting op 11.
  - MUL runs WIDTH cycles (one shift-add step per cycle), then goes to DONE.
  - DONE loads the output register, sets out_valid, and returns to IDLE when the output register is free.
  - MUL latency: WIDTH+1 cycles from accept to out_valid.
  - busy = (state != IDLE). in_ready is 0 while busy.
- Reset (rst_n low at a clock edge):
  - out_valid = 0; out_result = 0; out_tag = 0; all flags = 0; state = IDLE; multiplier registers = 0.
  - in_ready is 0 while rst_n is low.
  - Reset mid-multiply aborts it and produces no result.
- Arithmetic: all arithmetic is modulo 2^WIDTH. Overflow = (a_sign == b'_sign) && (sum_sign != a_sign), where b' is the post-inversion operand.

Optional Feature:
- Macro ALU_PIPE_MUL_EN.
- Defined: op 11 runs the iterative multiply described above; the MUL and DONE states exist.
- Undefined: op 11 behaves like ops 12-15 (single-cycle, result 0, out_zero = 1); the FSM is IDLE-only and busy is tied to 0.

Decomposition:
- Package alu_pkg holds:
  - typedef enum logic [3:0] alu_op_e covering all 16 codes;
  - typedef enum state_e {IDLE, MUL, DONE};
  - a function computing flags from (op, a, b', sum with carry).
- One sub-module, alu_mul_seq: a start/done shift-add multiplier parametrised by WIDTH, instantiated only under ALU_PIPE_MUL_EN.

Test Plan (all with WIDTH=32):
- ADD 0x7FFFFFFF + 1, out_ready=1 -> next cycle result 0x80000000, ovf=1, carry=0, zero=0.
- SUB 5 - 5 -> result 0, zero=1, carry=1, ovf=0. SUB 3 - 5 -> result 0xFFFFFFFE, carry=0.
- SRA a=0x80000000, b=0x00000024 (shift amount 4) -> 0xF8000000. SLL 1 by b=0x21 -> 0x00000002.
- Back-to-back: 8 ops issued on consecutive cycles with in_tag 0..7 and out_ready=1 -> 8 results on consecutive cycles, tags in order. Then hold out_ready=0 for 3 cycles -> in_ready=0 and outputs stable; release -> the next op is accepted in the same cycle.
- MUL (macro defined): 0x00010003 * 0x00000007 -> busy for 33 cycles, in_ready=0 throughout, result 0x00070015. Without the macro -> result 0, zero=1 after 1 cycle.
- Drop rst_n for 1 cycle at step 10 of a MUL -> next cycle state IDLE, out_valid=0, no result emitted, in_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/state types and the ADD/SUB flag helper for the EX-stage ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SRA   = 4'd2,
    OP_SRL   = 4'd3,
    OP_SLL   = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_XOR   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_PASSB = 4'd10,
    OP_MUL   = 4'd11,
    OP_RSV12 = 4'd12,
    OP_RSV13 = 4'd13,
    OP_RSV14 = 4'd14,
    OP_RSV15 = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  typedef struct packed {
    logic carry;
    logic ovf;
  } alu_flags_t;

  // Only the sign bits of a, b' and the sum plus the adder carry-out matter.
  function automatic alu_flags_t alu_flags(alu_op_e op, logic a_sign, logic bp_sign,
                                           logic sum_sign, logic carry_out);
    alu_flags_t f;
    f = '0;
    if (op == OP_ADD || op == OP_SUB) begin
      f.carry = carry_out;
      f.ovf   = (a_sign == bp_sign) && (sum_sign != a_sign);
    end
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Start/done shift-add multiplier: low WIDTH bits of a*b, one partial product per cycle.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;

  // Bit 0 is folded into the start cycle, so WIDTH-1 further steps remain.
  always_comb begin
    run_d    = run_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      run_d    = 1'b1;
      cnt_d    = CNT_W'(WIDTH - 1);
      acc_d    = b[0] ? a : '0;
      mcand_d  = a << 1;
      mplier_d = b >> 1;
    end else if (run_q) begin
      if (cnt_q != '0) begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
      end else begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign done    = run_q && (cnt_q == '0);
  assign product = acc_q;

endmodule

// File: rtl/alu_pipe.sv
// Registered EX-stage ALU with valid/ready on both sides.
// Macro ALU_PIPE_MUL_EN enables the iterative multi-cycle multiply for op 11.
module alu_pipe import alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             busy
);

  localparam int SH_W = $clog2(WIDTH);

  alu_op_e                 op;
  logic                    accept, out_free, load_alu;
  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]        bp, alu_res;
  logic [WIDTH:0]          sum;
  logic [SH_W-1:0]         shamt;
  alu_flags_t              alu_f;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;

  assign op       = alu_op_e'(in_op);
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid_q || out_ready;
  assign a_s      = in_a;
  assign b_s      = in_b;

  always_comb begin
    shamt   = in_b[SH_W-1:0];
    bp      = (op == OP_SUB) ? ~in_b : in_b;
    sum     = {1'b0, in_a} + {1'b0, bp} + {{WIDTH{1'b0}}, (op == OP_SUB)};
    alu_res = '0;
    case (op)
      OP_ADD, OP_SUB: alu_res = sum[WIDTH-1:0];
      OP_SRA:         alu_res = a_s >>> shamt;
      OP_SRL:         alu_res = in_a >> shamt;
      OP_SLL:         alu_res = in_a << shamt;
      OP_AND:         alu_res = in_a & in_b;
      OP_OR:          alu_res = in_a | in_b;
      OP_XOR:         alu_res = in_a ^ in_b;
      OP_SLT:         alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLTU:        alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      OP_PASSB:       alu_res = in_b;
      default:        alu_res = '0;
    endcase
    alu_f = alu_flags(op, in_a[WIDTH-1], bp[WIDTH-1], sum[WIDTH-1], sum[WIDTH]);
  end

`ifdef ALU_PIPE_MUL_EN
  state_e           state_q, state_d;
  logic             mul_start, mul_done;
  logic [WIDTH-1:0] mul_prod;

  assign mul_start = accept && (op == OP_MUL);
  assign load_alu  = accept && (op != OP_MUL);
  assign busy      = (state_q != IDLE);
  assign in_ready  = rst_n && (state_q == IDLE) && out_free;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (in_a),
    .b       (in_b),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign load_alu = accept;
  assign busy     = 1'b0;
  assign in_ready = rst_n && out_free;
`endif

  // Output register stage: drained by a transfer, refilled by an accept or a finished multiply.
  always_comb begin
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    tag_d       = tag_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    if (load_alu) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      tag_d       = in_tag;
      zero_d      = (alu_res == '0);
      carry_d     = alu_f.carry;
      ovf_d       = alu_f.ovf;
    end
`ifdef ALU_PIPE_MUL_EN
    state_d = state_q;
    case (state_q)
      IDLE: if (mul_start) state_d = MUL;
      // Nothing is accepted while MUL runs, so the output register is already empty here.
      MUL: if (mul_done) begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        result_d    = mul_prod;
        zero_d      = (mul_prod == '0);
        carry_d     = 1'b0;
        ovf_d       = 1'b0;
      end
      DONE: if (out_free) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (mul_start) tag_d = in_tag;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      tag_q       <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      state_q     <= IDLE;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      tag_q       <= tag_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
`ifdef ALU_PIPE_MUL_EN
      state_q     <= state_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_tag    = tag_q;
  assign out_zero   = zero_q;
  assign out_carry  = carry_q;
  assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=32): directed cases plus random traffic vs a reference model.
module tb_alu_pipe;

  localparam logic [3:0] OPC_ADD = 4'd0, OPC_SUB = 4'd1, OPC_SRA = 4'd2, OPC_SLL = 4'd4,
                         OPC_OR  = 4'd6, OPC_MUL = 4'd11;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  in_tag, out_tag;
  logic        out_zero, out_carry, out_ovf, busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic [2:0]  flags;  // {carry, ovf, zero}
  } exp_t;

  exp_t        q[$];
  logic        stall_prev = 1'b0;
  logic [31:0] held_res;
  logic [4:0]  held_tag;
  logic [2:0]  held_flags;

  alu_pipe #(.WIDTH(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_zero(out_zero), .out_carry(out_carry),
    .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] tag);
    exp_t e;
    longint sa, sb, ss;
    longint unsigned ua, ub;
    int sh;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    sh = int'(b % 32);
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      4'd0: begin ss = sa + sb; e.res = 32'(ua + ub); c = (ua + ub) > 64'hFFFF_FFFF; v = (ss > SMAX) || (ss < SMIN); end
      4'd1: begin ss = sa - sb; e.res = a - b; c = (a >= b); v = (ss > SMAX) || (ss < SMIN); end
      4'd2: e.res = 32'($signed(a) >>> sh);
      4'd3: e.res = a >> sh;
      4'd4: e.res = a << sh;
      4'd5: e.res = a & b;
      4'd6: e.res = a | b;
      4'd7: e.res = a ^ b;
      4'd8: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd9: e.res = (a < b) ? 32'd1 : 32'd0;
      4'd10: e.res = b;
`ifdef ALU_PIPE_MUL_EN
      4'd11: e.res = 32'(ua * ub);
`endif
      default: e.res = 32'd0;
    endcase
    e.tag   = tag;
    e.flags = {c, v, (e.res == 32'd0)};
    return e;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: every accepted op must come out once, in order, unchanged while stalled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check_eq("stall_valid", out_valid, 1);
          check_eq("stall_result", out_result, held_res);
          check_eq("stall_tag", out_tag, held_tag);
          check_eq("stall_flags", {out_carry, out_ovf, out_zero}, held_flags);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            check_eq("unexpected_output", q.size(), 1);
          end else begin
            e = q.pop_front();
            check_eq("sb_result", out_result, e.res);
            check_eq("sb_tag", out_tag, e.tag);
            check_eq("sb_flags", {out_carry, out_ovf, out_zero}, e.flags);
          end
        end
        stall_prev = out_valid && !out_ready;
        held_res   = out_result;
        held_tag   = out_tag;
        held_flags = {out_carry, out_ovf, out_zero};
        if (in_valid && in_ready) q.push_back(model(in_op, in_a, in_b, in_tag));
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output int waited);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    waited   = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 100);
    if (!in_ready) check_eq("issue_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int w, busy_cnt, first_valid, seen, t;
    logic [31:0] mres;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_result", out_result, 0);
    check_eq("rst_tag", out_tag, 0);
    check_eq("rst_flags", {out_carry, out_ovf, out_zero}, 3'b000);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    issue(OPC_ADD, 32'h7FFF_FFFF, 32'h1, 5'd1, w);
    check_eq("add_valid", out_valid, 1);
    check_eq("add_result", out_result, 32'h8000_0000);
    check_eq("add_flags", {out_carry, out_ovf, out_zero}, 3'b010);
    issue(OPC_SUB, 32'd5, 32'd5, 5'd2, w);
    check_eq("sub_eq_result", out_result, 32'h0);
    check_eq("sub_eq_flags", {out_carry, out_ovf, out_zero}, 3'b101);
    issue(OPC_SUB, 32'd3, 32'd5, 5'd3, w);
    check_eq("sub_lt_result", out_result, 32'hFFFF_FFFE);
    check_eq("sub_lt_flags", {out_carry, out_ovf, out_zero}, 3'b000);
    issue(OPC_SRA, 32'h8000_0000, 32'h24, 5'd4, w);
    check_eq("sra_result", out_result, 32'hF800_0000);
    issue(OPC_SLL, 32'h1, 32'h21, 5'd5, w);
    check_eq("sll_result", out_result, 32'h2);

    for (int i = 0; i < 8; i++) begin
      issue(OPC_ADD, 32'(i), 32'h100, 5'(i), w);
      check_eq("b2b_wait", w, 1);
      check_eq("b2b_valid", out_valid, 1);
      check_eq("b2b_tag", out_tag, i);
      check_eq("b2b_result", out_result, 32'(i + 256));
    end

    out_ready = 1'b0;
    in_valid = 1'b1; in_op = OPC_OR; in_a = 32'hF0; in_b = 32'h0F; in_tag = 5'd20;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("hold_in_ready", in_ready, 0);
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_tag", out_tag, 7);
      check_eq("hold_result", out_result, 32'h107);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("release_tag", out_tag, 20);
    check_eq("release_result", out_result, 32'hFF);

`ifdef ALU_PIPE_MUL_EN
    issue(OPC_MUL, 32'h0001_0003, 32'h7, 5'd9, w);
    busy_cnt = 0; first_valid = -1; mres = '0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (busy) begin
        busy_cnt++;
        check_eq("mul_in_ready", in_ready, 0);
      end
      if (out_valid && first_valid < 0) begin
        first_valid = k;
        mres = out_result;
      end
      if (!busy) break;
    end
    check_eq("mul_busy_cycles", busy_cnt, 33);
    check_eq("mul_latency", first_valid, 32);
    check_eq("mul_result", mres, 32'h0007_0015);
    @(posedge clk); #1;

    issue(OPC_MUL, 32'h1234_5678, 32'h09AB_CDEF, 5'd11, w);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_valid", out_valid, 0);
    check_eq("abort_in_ready", in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("abort_no_result", seen, 0);
    @(posedge clk); #1;
`else
    issue(OPC_MUL, 32'h0001_0003, 32'h7, 5'd9, w);
    check_eq("mul_off_valid", out_valid, 1);
    check_eq("mul_off_result", out_result, 32'h0);
    check_eq("mul_off_flags", {out_carry, out_ovf, out_zero}, 3'b001);
    check_eq("mul_off_busy", busy, 0);
`endif

    for (int c = 0; c < 500; c++) begin
      in_valid  = ($urandom % 4) != 0;
      in_op     = 4'($urandom % 16);
      in_a      = pick();
      in_b      = pick();
      in_tag    = 5'($urandom);
      out_ready = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("drain_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
